// File: rtl/ysyx_23060201_sram_pkg.sv
// Shared definitions for the ysyx_23060201 SRAM responder.
// Holds the FSM state encoding, the default base address, the LFSR seed
// and the LFSR step function used by the optional random-delay feature
// (enabled by defining YSYX_23060201_SRAM_RAND_DELAY_EN).
package ysyx_23060201_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] SRAM_BASE_ADDR_DEFAULT = 32'h8000_0000;
  localparam logic [3:0]  LFSR_SEED              = 4'b1001;
  localparam int unsigned SRAM_BYTES             = 4;

  // Fibonacci step for x^4 + x^3 + 1
  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/ysyx_23060201_sram_lfsr.sv
// 4-bit LFSR (x^4 + x^3 + 1) supplying extra response delay.
// Ports: clk, rst (async active-high, reloads seed 4'b1001),
//        i_en (advance one step), o_lfsr (current state).
// Only instantiated when YSYX_23060201_SRAM_RAND_DELAY_EN is defined.
module ysyx_23060201_LFSR
  import ysyx_23060201_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic [3:0] o_lfsr
);

  logic [3:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/ysyx_23060201_sram.sv
// Single-outstanding word SRAM responder with valid/ready request and
// response channels and a fixed (or optionally randomised) latency.
// Parameters: LATENCY (accept-to-response cycles, >=1), DEPTH (32-bit
// words), BASE_ADDR (byte address of word 0).
// Ports: clk, rst (async active-high); request channel req_valid/req_ready,
// req_wen, req_addr, req_wdata, req_wmask[3:0] byte enables ([7:4] ignored);
// response channel rsp_valid/rsp_ready, rsp_rdata, rsp_err (address out of
// range). Define YSYX_23060201_SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven
// extra busy cycles per request.
module ysyx_23060201_sram
  import ysyx_23060201_sram_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(LATENCY + 4) + 1;
  localparam logic [31:0] SPAN = 32'(SRAM_BYTES * DEPTH);
  localparam logic [CW-1:0] BASE_BUSY = CW'(LATENCY - 1);

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [CW-1:0]   w_busy_cycles;

  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [31:0]     r_rsp_rdata;

  logic            r_wen;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wmask;

  logic [31:0]     r_mem [DEPTH];

  logic            w_hs;
  logic            w_rsp_hs;
  logic            w_commit;
  logic            w_use_req;
  logic            w_acc_wen;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [3:0]      w_acc_wmask;
  logic [31:0]     w_off;
  logic            w_in_range;
  logic [AW-1:0]   w_idx;
  logic            w_unused;

  assign w_hs     = req_valid && r_req_ready;
  assign w_rsp_hs = r_rsp_valid && rsp_ready;

`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
  logic [3:0] w_lfsr;

  ysyx_23060201_LFSR u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_hs),
    .o_lfsr (w_lfsr)
  );

  // Extra delay is sampled before the LFSR advances on this handshake
  assign w_busy_cycles = BASE_BUSY + CW'(w_lfsr[1:0]);
  assign w_unused      = ^{req_wmask[7:4], w_lfsr[3:2]};
`else
  assign w_busy_cycles = BASE_BUSY;
  assign w_unused      = ^req_wmask[7:4];
`endif

  // In IDLE the access (LATENCY=1 path) uses live inputs; otherwise the latched request
  assign w_use_req   = (r_state == ST_IDLE);
  assign w_acc_wen   = w_use_req ? req_wen         : r_wen;
  assign w_acc_addr  = w_use_req ? req_addr        : r_addr;
  assign w_acc_wdata = w_use_req ? req_wdata       : r_wdata;
  assign w_acc_wmask = w_use_req ? req_wmask[3:0]  : r_wmask;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range test
  assign w_off      = w_acc_addr - BASE_ADDR;
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = w_off[AW+1:2];

  assign w_commit = (w_state_next == ST_RESP) && (r_state != ST_RESP);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (w_busy_cycles == '0) begin
            w_state_next = ST_RESP;
          end else begin
            w_state_next = ST_BUSY;
            w_cnt_next   = w_busy_cycles;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt <= CW'(1)) begin
          w_state_next = ST_RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State register and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_state_next == ST_IDLE);
      r_rsp_valid <= (w_state_next == ST_RESP);
    end
  end

  // Request latch and response payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask[3:0];
      end
      if (w_commit) begin
        r_rsp_rdata <= (!w_acc_wen && w_in_range) ? r_mem[w_idx] : '0;
        r_rsp_err   <= !w_in_range;
      end
    end
  end

  // Storage: not reset, byte-masked write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (w_commit && w_acc_wen && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/ysyx_23060201_sram.md
YSYX_23060201_SRAM -- requirements
Module: ysyx_23060201_SRAM

Interface
REQ-001 Parameters SHALL be: LATENCY, default 1, request-accept-to-response cycles (>=1); DEPTH, default 1024, storage size in 32-bit words; BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 Port clk input 1: single clock, all state on rising edge.
REQ-003 Port rst input 1: asynchronous, active-high reset.
REQ-004 Port req_valid input 1: initiator presents a request.
REQ-005 Port req_ready output 1: responder accepts the request this cycle.
REQ-006 Port req_wen input 1: 1 = write, 0 = read.
REQ-007 Port req_addr input 32: byte address; bits [1:0] ignored (word access).
REQ-008 Port req_wdata input 32: write data.
REQ-009 Port req_wmask input 8: byte enables; bits [3:0] map to bytes 0..3; bits [7:4] ignored.
REQ-010 Port rsp_valid output 1: response available.
REQ-011 Port rsp_ready input 1: initiator consumes the response.
REQ-012 Port rsp_rdata output 32: read data; 0 for writes and errors.
REQ-013 Port rsp_err output 1: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH).

Function
REQ-014 FSM states SHALL be IDLE, BUSY, RESP; one request is outstanding at most.
REQ-015 req_ready SHALL be 1 only in IDLE; handshake fires when req_valid && req_ready at a rising edge.
REQ-016 On handshake, wen/addr/wdata/wmask SHALL be latched; later input changes SHALL have no effect.
REQ-017 After handshake the FSM SHALL spend LATENCY-1 cycles in BUSY, then enter RESP; with LATENCY=1 it SHALL enter RESP directly, so rsp_valid is high the cycle after accept.
REQ-018 The access SHALL be performed on the edge entering RESP: writes update only bytes with wmask bit set; read data is registered into rsp_rdata.
REQ-019 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESP until rsp_valid && rsp_ready at an edge, then FSM returns to IDLE.
REQ-020 A new request SHALL NOT be accepted in the same cycle a response is consumed (req_ready low in RESP).
REQ-021 Out-of-range address SHALL yield rsp_err=1, rsp_rdata=0, no storage modification, same latency.
REQ-022 Word index SHALL be (addr-BASE_ADDR)>>2; no wrap-around within storage.
REQ-023 Read-after-write to same word SHALL return the written data.
REQ-024 req_valid may be asserted in any state; it is ignored unless in IDLE.

Reset
REQ-025 On rst high, state SHALL go IDLE asynchronously; rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after release; BUSY counter=0.
REQ-026 Reset in BUSY SHALL discard the pending request; an uncommitted write SHALL not modify storage.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 With YSYX_23060201_SRAM_RAND_DELAY_EN defined, each accepted request SHALL add lfsr[1:0] (0..3) extra BUSY cycles from a 4-bit LFSR (x^4+x^3+1), seed 4'b1001 on reset, advanced once per handshake.
REQ-029 Without the macro, latency SHALL be exactly LATENCY and no LFSR logic SHALL exist.

Structure
REQ-030 FSM state encodings and default BASE_ADDR SHALL live in the shared defines.v header.
REQ-031 The LFSR SHALL be sub-module ysyx_23060201_LFSR, instantiated only under the macro.

Verification
REQ-032 LATENCY=1: write 0x8000_0004 data 0xDEADBEEF mask 0x0F, then read it -> rsp_valid one cycle after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 Partial write mask 0x02 data 0x0000AB00 over 0xDEADBEEF -> read returns 0xDEADABEF.
REQ-034 Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> rsp_err=1, rdata=0, storage unchanged.
REQ-035 LATENCY=3, hold rsp_ready=0 for 5 cycles -> rsp_valid at accept+3, rdata stable throughout, req_ready=0 until consumed.
REQ-036 Assert rst during BUSY of a write (LATENCY=4) -> rsp_valid=0 immediately, later read of that word returns prior value.
REQ-037 Macro defined, 16 back-to-back reads -> every response latency in [LATENCY, LATENCY+3], sequence identical after each reset.
